instr_fetch_unit: RTL and testbench

- Front end of the 16-bit core. Produces the 3-bit opcode and the 16-bit instruction word that the opcode decoder consumes.
- Takes back the decoder's PC-select outputs (pcsrc, branch) and the ALU zero flag, and uses them to form the next PC.
- Talks to instruction memory over a variable-latency req/ack handshake.
- Holds each instruction stable until the execute side accepts it.

---
 rtl/instr_fetch_unit.sv | 94 +++++++++
 tb/tb_instr_fetch_unit.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/instr_fetch_unit.sv
// Instruction fetch front end: requests a word from instruction memory, holds it for the
// execute side, and forms the next PC from the decoder's pcsrc/branch outputs and the ALU zero flag.
module instr_fetch_unit #(
   parameter logic [15:0] RESET_PC = 16'h0000,
   parameter int          CNT_W    = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   output logic             imem_req,
   output logic [15:0]      imem_addr,
   input  logic             imem_ack,
   input  logic [15:0]      imem_rdata,
   output logic [15:0]      instr,
   output logic [2:0]       opcode,
   output logic [15:0]      pc_out,
   output logic             instr_valid,
   input  logic             instr_accept,
   input  logic [1:0]       pcsrc,
   input  logic             branch,
   input  logic             zero,
   output logic             illegal_pcsrc,
   output logic [CNT_W-1:0] retired_cnt,
   output logic             dbgState
);

   typedef enum logic {REQ = 1'b0, HOLD = 1'b1} stateT;

   // Handshake: a fetch completes on a cycle where imem_req && imem_ack; an instruction
   // is consumed on a cycle where instr_valid && instr_accept. Either side may stall indefinitely.

   stateT             state, nextState;
   logic [15:0]       pc, pcNext, pc2, brTarget, jmpTarget;
   logic [15:0]       instrQ;
   logic              reqQ, illegalQ, capture, retire;
   logic [CNT_W-1:0]  retiredQ;

   always_comb begin
      nextState = state;
      pcNext    = pc;
      capture   = 1'b0;
      retire    = 1'b0;
      pc2       = pc + 16'd2;
      brTarget  = pc2 + {{8{instrQ[6]}}, instrQ[6:0], 1'b0};
      jmpTarget = {pc[15:14], instrQ[12:0], 1'b0};
      case (state)
         REQ: begin
            // reqQ gates the ack so the cycle right after reset ignores a stray ack
            if (reqQ && imem_ack) begin
               capture   = 1'b1;
               nextState = HOLD;
            end
         end
         HOLD: begin
            if (instr_accept) begin
               retire    = 1'b1;
               nextState = REQ;
               if (branch && zero)       pcNext = brTarget;
               else if (pcsrc == 2'b10)  pcNext = jmpTarget;
               else                      pcNext = pc2;
            end
         end
         default: nextState = REQ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= REQ;
         pc       <= RESET_PC;
         reqQ     <= 1'b0;
         instrQ   <= 16'h0000;
         illegalQ <= 1'b0;
         retiredQ <= '0;
      end else begin
         state <= nextState;
         pc    <= pcNext;
         reqQ  <= (nextState == REQ);
         if (capture)              instrQ   <= imem_rdata;
         if (retire && pcsrc[0])   illegalQ <= 1'b1;
         if (retire)               retiredQ <= retiredQ + CNT_W'(1);
      end
   end

   assign imem_req      = reqQ;
   assign imem_addr     = pc;
   assign instr         = instrQ;
   assign opcode        = instrQ[15:13];
   assign pc_out        = pc;
   assign instr_valid   = (state == HOLD);
   assign illegal_pcsrc = illegalQ;
   assign retired_cnt   = retiredQ;
   assign dbgState      = state;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Directed bench for instr_fetch_unit: a table of fetch/accept records walked through
// a PC chain, plus hand-written reset and stray-ack sequences.
module tb_instr_fetch_unit;

   logic        clk, rst_n;
   logic        imem_req, imem_ack;
   logic [15:0] imem_addr, imem_rdata, instr, pc_out;
   logic [2:0]  opcode;
   logic        instr_valid, instr_accept, branch, zero, illegal_pcsrc, dbgState;
   logic [1:0]  pcsrc;
   logic [15:0] retired_cnt;

   int checks   = 0;
   int failures = 0;
   int expRetired = 0;
   logic [15:0] expQ[$];

   typedef struct {
      logic [15:0] addr;
      logic [15:0] rdata;
      logic [1:0]  pcsrc;
      logic        br;
      logic        z;
      int          ackDly;
      int          hold;
      logic [15:0] nextAddr;
      logic        illegal;
   } vecT;

   vecT vecs[17];

   instr_fetch_unit #(.RESET_PC(16'h0000), .CNT_W(16)) dut (
      .clk(clk), .rst_n(rst_n),
      .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack), .imem_rdata(imem_rdata),
      .instr(instr), .opcode(opcode), .pc_out(pc_out), .instr_valid(instr_valid),
      .instr_accept(instr_accept), .pcsrc(pcsrc), .branch(branch), .zero(zero),
      .illegal_pcsrc(illegal_pcsrc), .retired_cnt(retired_cnt), .dbgState(dbgState)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, exp);
      end
   endtask

   task automatic waitReq();
      int n = 0;
      while (imem_req !== 1'b1 && n < 20) begin
         @(negedge clk);
         n++;
      end
      check("req_timeout", imem_req, 1);
   endtask

   task automatic applyVec(input vecT v);
      logic [15:0] expAddr;
      waitReq();
      expAddr = (expQ.size() > 0) ? expQ.pop_front() : v.addr;
      check("req_addr", imem_addr, expAddr);
      check("valid_in_req", instr_valid, 0);
      for (int d = 0; d < v.ackDly; d++) begin
         instr_accept = 1'b1; pcsrc = 2'b01; branch = 1'b1; zero = 1'b1;
         @(negedge clk);
         check("req_held", imem_req, 1);
         check("addr_stable", imem_addr, v.addr);
         check("valid_wait", instr_valid, 0);
      end
      imem_ack = 1'b1; imem_rdata = v.rdata;
      @(negedge clk);
      imem_ack = 1'b0; imem_rdata = ~v.rdata; instr_accept = 1'b0;
      pcsrc = 2'b00; branch = 1'b0; zero = 1'b0;
      check("valid_after_ack", instr_valid, 1);
      check("instr", instr, v.rdata);
      check("opcode", opcode, v.rdata[15:13]);
      check("pc_out", pc_out, v.addr);
      check("req_drop", imem_req, 0);
      check("retired_hold", retired_cnt, expRetired);
      for (int h = 0; h < v.hold; h++) begin
         imem_ack = 1'b1;
         @(negedge clk);
         check("hold_instr", instr, v.rdata);
         check("hold_valid", instr_valid, 1);
         check("hold_no_req", imem_req, 0);
      end
      imem_ack = 1'b0; instr_accept = 1'b1;
      pcsrc = v.pcsrc; branch = v.br; zero = v.z;
      @(negedge clk);
      instr_accept = 1'b0; pcsrc = 2'b00; branch = 1'b0; zero = 1'b0;
      expRetired++;
      expQ.push_back(v.nextAddr);
      check("valid_after_accept", instr_valid, 0);
      check("req_after_accept", imem_req, 1);
      check("next_addr", imem_addr, v.nextAddr);
      check("retired", retired_cnt, expRetired);
      check("illegal", illegal_pcsrc, v.illegal);
   endtask

   initial begin
      vecT restart;
      //             addr      rdata     pcsrc  br    z    dly hold next      ill
      vecs[0]  = '{16'h0000, 16'h0000, 2'b00, 1'b0, 1'b0, 5, 0, 16'h0002, 1'b0};
      vecs[1]  = '{16'h0002, 16'h0000, 2'b00, 1'b0, 1'b0, 0, 0, 16'h0004, 1'b0};
      vecs[2]  = '{16'h0004, 16'hE005, 2'b10, 1'b0, 1'b0, 0, 0, 16'h000A, 1'b0};
      vecs[3]  = '{16'h000A, 16'hE008, 2'b10, 1'b0, 1'b0, 1, 0, 16'h0010, 1'b0};
      vecs[4]  = '{16'h0010, 16'h807E, 2'b00, 1'b1, 1'b0, 0, 0, 16'h0012, 1'b0};
      vecs[5]  = '{16'h0012, 16'hE008, 2'b10, 1'b0, 1'b0, 0, 0, 16'h0010, 1'b0};
      vecs[6]  = '{16'h0010, 16'h807E, 2'b00, 1'b1, 1'b1, 0, 4, 16'h000E, 1'b0};
      vecs[7]  = '{16'h000E, 16'hE008, 2'b10, 1'b0, 1'b0, 0, 0, 16'h0010, 1'b0};
      vecs[8]  = '{16'h0010, 16'h807E, 2'b10, 1'b1, 1'b1, 2, 1, 16'h000E, 1'b0};
      vecs[9]  = '{16'h000E, 16'hE000, 2'b10, 1'b0, 1'b0, 0, 0, 16'h0000, 1'b0};
      vecs[10] = '{16'h0000, 16'h807E, 2'b00, 1'b1, 1'b1, 0, 0, 16'hFFFE, 1'b0};
      vecs[11] = '{16'hFFFE, 16'hE002, 2'b10, 1'b0, 1'b0, 0, 0, 16'hC004, 1'b0};
      vecs[12] = '{16'hC004, 16'hE005, 2'b10, 1'b0, 1'b0, 0, 0, 16'hC00A, 1'b0};
      vecs[13] = '{16'hC00A, 16'hFFFF, 2'b10, 1'b0, 1'b0, 0, 0, 16'hFFFE, 1'b0};
      vecs[14] = '{16'hFFFE, 16'h0000, 2'b00, 1'b0, 1'b0, 0, 0, 16'h0000, 1'b0};
      vecs[15] = '{16'h0000, 16'h0000, 2'b01, 1'b0, 1'b0, 0, 0, 16'h0002, 1'b1};
      vecs[16] = '{16'h0002, 16'h1000, 2'b00, 1'b0, 1'b0, 3, 0, 16'h0004, 1'b1};
      restart  = '{16'h0000, 16'h2000, 2'b00, 1'b0, 1'b0, 0, 0, 16'h0002, 1'b0};

      rst_n = 1'b0; imem_ack = 1'b0; imem_rdata = 16'h0000;
      instr_accept = 1'b0; pcsrc = 2'b00; branch = 1'b0; zero = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_req", imem_req, 0);
      check("rst_valid", instr_valid, 0);
      check("rst_instr", instr, 16'h0000);
      check("rst_addr", imem_addr, 16'h0000);
      check("rst_illegal", illegal_pcsrc, 0);
      check("rst_retired", retired_cnt, 0);
      check("rst_state", dbgState, 0);

      // stray ack while imem_req is still low after reset must be ignored
      imem_ack = 1'b1; imem_rdata = 16'h1234; rst_n = 1'b1;
      @(negedge clk);
      imem_ack = 1'b0;
      check("first_req", imem_req, 1);
      check("stray_ack_valid", instr_valid, 0);

      for (int i = 0; i < 17; i++) applyVec(vecs[i]);

      // reset asserted in REQ together with an ack
      imem_ack = 1'b1; imem_rdata = 16'hABCD; rst_n = 1'b0;
      #1;
      check("mid_rst_req", imem_req, 0);
      check("mid_rst_valid", instr_valid, 0);
      check("mid_rst_instr", instr, 16'h0000);
      check("mid_rst_illegal", illegal_pcsrc, 0);
      check("mid_rst_retired", retired_cnt, 0);
      check("mid_rst_addr", imem_addr, 16'h0000);
      @(negedge clk);
      check("mid_rst_ack_ignored", instr, 16'h0000);
      check("mid_rst_state", dbgState, 0);
      imem_ack = 1'b0; rst_n = 1'b1;
      expRetired = 0;
      expQ.delete();
      applyVec(restart);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
